// File: rtl/id_issue_unit_if.sv
// rtl/id_issue_unit_if.sv - IF/ID consume handshake and ID/EX issue fields of the issue stage
interface id_issue_unit_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;
    logic [4:0]  OpCode;
    logic [8:0]  Rd;
    logic [8:0]  Rs;
    logic [8:0]  Rt;
    logic [26:0] Dir;
    logic        issue_valid;
    logic [15:0] stall_cnt;

    modport master (
        output instr, instr_valid, flush,
        input  instr_ready, OpCode, Rd, Rs, Rt, Dir, issue_valid, stall_cnt
    );

    modport slave (
        input  instr, instr_valid, flush,
        output instr_ready, OpCode, Rd, Rs, Rt, Dir, issue_valid, stall_cnt
    );
endinterface

// File: rtl/id_issue_unit.sv
// rtl/id_issue_unit.sv - decode/issue stage with write scoreboard, bubble insertion and fetch back-pressure
// Optional: define ID_ISSUE_FORWARD_EN to limit RAW stalls to the single load-use bubble.
module id_issue_unit #(
    parameter int          SB_ENTRIES = 4,
    parameter int          WB_LAT     = 3,
    parameter logic [31:0] WR_MASK    = 32'h0000_FFFE,
    parameter logic [31:0] RS_MASK    = 32'h0000_FFFE,
    parameter logic [31:0] RT_MASK    = 32'h0000_0FFE,
    parameter logic [31:0] LOAD_MASK  = 32'h0000_1000
) (
    input  logic           clk,
    input  logic           rst_n,
    id_issue_unit_if.slave bus
);
    localparam int         IDX_W   = (SB_ENTRIES > 1) ? $clog2(SB_ENTRIES) : 1;
    localparam logic [3:0] WB_LAT4 = 4'(WB_LAT);

    logic [4:0] op;
    logic [8:0] rd, rs, rt;
    logic       wr, rs_rd, rt_rd;

    logic [SB_ENTRIES-1:0] sb_valid;
    logic [SB_ENTRIES-1:0] sb_load;
    logic [8:0]            sb_rd  [SB_ENTRIES];
    logic [3:0]            sb_cnt [SB_ENTRIES];

    logic             hazard, any_free, full, raw, issue, alloc;
    logic [IDX_W-1:0] alloc_idx;
    logic [15:0]      stall_q;

    assign op    = bus.instr[31:27];
    assign rd    = bus.instr[26:18];
    assign rs    = bus.instr[17:9];
    assign rt    = bus.instr[8:0];
    assign wr    = WR_MASK[op] && (rd != 9'd0);
    assign rs_rd = RS_MASK[op] && (rs != 9'd0);
    assign rt_rd = RT_MASK[op] && (rt != 9'd0);

    // Downward scan so the lowest free slot is the last one recorded.
    always_comb begin
        hazard    = 1'b0;
        any_free  = 1'b0;
        raw       = 1'b0;
        alloc_idx = '0;
        for (int i = SB_ENTRIES - 1; i >= 0; i--) begin
            if (!sb_valid[i]) begin
                any_free  = 1'b1;
                alloc_idx = IDX_W'(i);
            end else begin
                raw = (rs_rd && (sb_rd[i] == rs)) || (rt_rd && (sb_rd[i] == rt));
`ifdef ID_ISSUE_FORWARD_EN
                raw = raw && sb_load[i] && (sb_cnt[i] == WB_LAT4);
`endif
                if (raw || (wr && (sb_rd[i] == rd)))
                    hazard = 1'b1;
            end
        end
    end

    assign full            = wr && !any_free;
    assign bus.instr_ready = !bus.instr_valid || (!hazard && !full && !bus.flush);
    assign issue           = bus.instr_valid && bus.instr_ready;
    assign alloc           = issue && wr;
    assign bus.stall_cnt   = stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.OpCode      <= '0;
            bus.Rd          <= '0;
            bus.Rs          <= '0;
            bus.Rt          <= '0;
            bus.Dir         <= '0;
            bus.issue_valid <= 1'b0;
        end else if (issue) begin
            bus.OpCode      <= op;
            bus.Rd          <= rd;
            bus.Rs          <= rs;
            bus.Rt          <= rt;
            bus.Dir         <= bus.instr[26:0];
            bus.issue_valid <= 1'b1;
        end else begin
            bus.OpCode      <= '0;
            bus.Rd          <= '0;
            bus.Rs          <= '0;
            bus.Rt          <= '0;
            bus.Dir         <= '0;
            bus.issue_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (bus.instr_valid && !bus.flush && (hazard || full) && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    // A slot freeing this edge is invisible to alloc_idx, which sees pre-edge state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid <= '0;
            sb_load  <= '0;
            for (int i = 0; i < SB_ENTRIES; i++) begin
                sb_rd[i]  <= '0;
                sb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SB_ENTRIES; i++) begin
                if (alloc && (IDX_W'(i) == alloc_idx)) begin
                    sb_valid[i] <= 1'b1;
                    sb_rd[i]    <= rd;
                    sb_load[i]  <= LOAD_MASK[op];
                    sb_cnt[i]   <= WB_LAT4;
                end else if (sb_valid[i]) begin
                    if (sb_cnt[i] == 4'd1)
                        sb_valid[i] <= 1'b0;
                    sb_cnt[i] <= sb_cnt[i] - 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_id_issue_unit.sv
// tb/tb_id_issue_unit.sv - directed self-checking bench for id_issue_unit
module tb_id_issue_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   exp_stall1 = 0;
    int   exp_stall2 = 0;

    always #5 clk = ~clk;

    id_issue_unit_if bus1();
    id_issue_unit_if bus2();

    id_issue_unit u_dut (.clk(clk), .rst_n(rst_n), .bus(bus1));
    id_issue_unit #(.SB_ENTRIES(4), .WB_LAT(6)) u_dut_deep (.clk(clk), .rst_n(rst_n), .bus(bus2));

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [8:0] rd,
                                       input logic [8:0] rs, input logic [8:0] rt);
        return {op, rd, rs, rt};
    endfunction

    task automatic idle1();
        bus1.instr_valid = 1'b0;
        bus1.instr = '0;
        bus1.flush = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus1.instr = '0; bus1.instr_valid = 1'b0; bus1.flush = 1'b0;
        bus2.instr = '0; bus2.instr_valid = 1'b0; bus2.flush = 1'b0;
        rst_n = 1'b0;
        #2;
        tests_run++; if (bus1.OpCode !== 5'd0) begin tests_failed++; $display("FAIL reset_opcode: got %0d want 0", bus1.OpCode); end
        tests_run++; if (bus1.issue_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_issue_valid: got %b want 0", bus1.issue_valid); end
        tests_run++; if (bus1.stall_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_stall_cnt: got %0d want 0", bus1.stall_cnt); end
        tests_run++; if (bus1.instr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_idle: got %b want 1", bus1.instr_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (bus1.issue_valid !== 1'b0 || bus1.Rd !== 9'd0) begin tests_failed++; $display("FAIL post_reset_idle: got v=%b rd=%0d want v=0 rd=0", bus1.issue_valid, bus1.Rd); end
    endtask

    task automatic test_issue();
        logic [31:0] w;
        w = mk(5'd1, 9'd5, 9'd1, 9'd2);
        bus1.instr = w; bus1.instr_valid = 1'b1;
        #1;
        tests_run++; if (bus1.instr_ready !== 1'b1) begin tests_failed++; $display("FAIL issue_ready: got %b want 1", bus1.instr_ready); end
        @(posedge clk); #1;
        tests_run++; if (bus1.OpCode !== 5'd1 || bus1.Rd !== 9'd5 || bus1.Rs !== 9'd1 || bus1.Rt !== 9'd2)
            begin tests_failed++; $display("FAIL issue_fields: got op=%0d rd=%0d rs=%0d rt=%0d want 1 5 1 2", bus1.OpCode, bus1.Rd, bus1.Rs, bus1.Rt); end
        tests_run++; if (bus1.Dir !== w[26:0]) begin tests_failed++; $display("FAIL issue_dir: got %0h want %0h", bus1.Dir, w[26:0]); end
        tests_run++; if (bus1.issue_valid !== 1'b1) begin tests_failed++; $display("FAIL issue_valid: got %b want 1", bus1.issue_valid); end
        idle1();
    endtask

    task automatic test_raw();
        int bubbles;
        int exp;
`ifdef ID_ISSUE_FORWARD_EN
        exp = 0;
`else
        exp = 3;
`endif
        bus1.instr = mk(5'd1, 9'd5, 9'd1, 9'd2); bus1.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus1.instr = mk(5'd1, 9'd6, 9'd5, 9'd0);
        bubbles = 0;
        while (1) begin
            #1;
            if (bus1.instr_ready) break;
            @(posedge clk); #1;
            tests_run++; if (bus1.OpCode !== 5'd0 || bus1.issue_valid !== 1'b0) begin tests_failed++; $display("FAIL raw_bubble: got op=%0d v=%b want 0 0", bus1.OpCode, bus1.issue_valid); end
            bubbles++;
            if (bubbles > 20) begin tests_run++; tests_failed++; $display("FAIL raw_timeout: got >20 stall cycles want %0d", exp); break; end
        end
        tests_run++; if (bubbles != exp) begin tests_failed++; $display("FAIL raw_bubbles: got %0d want %0d", bubbles, exp); end
        @(posedge clk); #1;
        exp_stall1 += exp;
        tests_run++; if (bus1.issue_valid !== 1'b1 || bus1.Rs !== 9'd5 || bus1.Rd !== 9'd6) begin tests_failed++; $display("FAIL raw_issue: got v=%b rs=%0d rd=%0d want 1 5 6", bus1.issue_valid, bus1.Rs, bus1.Rd); end
        tests_run++; if (bus1.stall_cnt !== 16'(exp_stall1)) begin tests_failed++; $display("FAIL raw_stall_cnt: got %0d want %0d", bus1.stall_cnt, exp_stall1); end
        idle1();
    endtask

    task automatic test_load_use();
        int bubbles;
        int exp;
`ifdef ID_ISSUE_FORWARD_EN
        exp = 1;
`else
        exp = 3;
`endif
        bus1.instr = mk(5'd12, 9'd7, 9'd3, 9'd0); bus1.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus1.instr = mk(5'd1, 9'd8, 9'd7, 9'd0);
        bubbles = 0;
        while (1) begin
            #1;
            if (bus1.instr_ready) break;
            @(posedge clk); #1;
            tests_run++; if (bus1.issue_valid !== 1'b0) begin tests_failed++; $display("FAIL load_bubble: got v=%b want 0", bus1.issue_valid); end
            bubbles++;
            if (bubbles > 20) begin tests_run++; tests_failed++; $display("FAIL load_timeout: got >20 stall cycles want %0d", exp); break; end
        end
        tests_run++; if (bubbles != exp) begin tests_failed++; $display("FAIL load_bubbles: got %0d want %0d", bubbles, exp); end
        @(posedge clk); #1;
        exp_stall1 += exp;
        tests_run++; if (bus1.issue_valid !== 1'b1 || bus1.Rs !== 9'd7) begin tests_failed++; $display("FAIL load_issue: got v=%b rs=%0d want 1 7", bus1.issue_valid, bus1.Rs); end
        tests_run++; if (bus1.stall_cnt !== 16'(exp_stall1)) begin tests_failed++; $display("FAIL load_stall_cnt: got %0d want %0d", bus1.stall_cnt, exp_stall1); end
        idle1();
    endtask

    task automatic test_flush();
        logic [31:0] w;
        w = mk(5'd2, 9'd8, 9'd3, 9'd4);
        bus1.instr = w; bus1.instr_valid = 1'b1; bus1.flush = 1'b1;
        #1;
        tests_run++; if (bus1.instr_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_ready: got %b want 0", bus1.instr_ready); end
        @(posedge clk); #1;
        tests_run++; if (bus1.issue_valid !== 1'b0 || bus1.OpCode !== 5'd0) begin tests_failed++; $display("FAIL flush_bubble: got v=%b op=%0d want 0 0", bus1.issue_valid, bus1.OpCode); end
        tests_run++; if (bus1.stall_cnt !== 16'(exp_stall1)) begin tests_failed++; $display("FAIL flush_stall_cnt: got %0d want %0d", bus1.stall_cnt, exp_stall1); end
        bus1.flush = 1'b0;
        #1;
        tests_run++; if (bus1.instr_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_release_ready: got %b want 1", bus1.instr_ready); end
        @(posedge clk); #1;
        tests_run++; if (bus1.issue_valid !== 1'b1 || bus1.OpCode !== 5'd2 || bus1.Rd !== 9'd8 || bus1.Rt !== 9'd4 || bus1.Dir !== w[26:0])
            begin tests_failed++; $display("FAIL flush_reissue: got v=%b op=%0d rd=%0d rt=%0d want 1 2 8 4", bus1.issue_valid, bus1.OpCode, bus1.Rd, bus1.Rt); end
        idle1();
    endtask

    task automatic test_full();
        int stalls;
        for (int k = 0; k < 4; k++) begin
            bus2.instr = mk(5'd1, 9'(10 + k), 9'd0, 9'd0); bus2.instr_valid = 1'b1;
            #1;
            tests_run++; if (bus2.instr_ready !== 1'b1) begin tests_failed++; $display("FAIL full_fill_ready%0d: got %b want 1", k, bus2.instr_ready); end
            @(posedge clk); #1;
            tests_run++; if (bus2.issue_valid !== 1'b1 || bus2.Rd !== 9'(10 + k)) begin tests_failed++; $display("FAIL full_fill_issue%0d: got v=%b rd=%0d want 1 %0d", k, bus2.issue_valid, bus2.Rd, 10 + k); end
        end
        bus2.instr = mk(5'd1, 9'd0, 9'd0, 9'd0);
        #1;
        tests_run++; if (bus2.instr_ready !== 1'b1) begin tests_failed++; $display("FAIL full_rd0_ready: got %b want 1", bus2.instr_ready); end
        @(posedge clk); #1;
        tests_run++; if (bus2.issue_valid !== 1'b1 || bus2.Rd !== 9'd0) begin tests_failed++; $display("FAIL full_rd0_issue: got v=%b rd=%0d want 1 0", bus2.issue_valid, bus2.Rd); end
        bus2.instr = mk(5'd1, 9'd14, 9'd0, 9'd0);
        stalls = 0;
        while (1) begin
            #1;
            if (bus2.instr_ready) break;
            @(posedge clk); #1;
            stalls++;
            if (stalls > 20) begin tests_run++; tests_failed++; $display("FAIL full_timeout: got >20 stall cycles want 2"); break; end
        end
        tests_run++; if (stalls != 2) begin tests_failed++; $display("FAIL full_stalls: got %0d want 2", stalls); end
        @(posedge clk); #1;
        exp_stall2 += 2;
        tests_run++; if (bus2.issue_valid !== 1'b1 || bus2.Rd !== 9'd14) begin tests_failed++; $display("FAIL full_fifth_issue: got v=%b rd=%0d want 1 14", bus2.issue_valid, bus2.Rd); end
        tests_run++; if (bus2.stall_cnt !== 16'(exp_stall2)) begin tests_failed++; $display("FAIL full_stall_cnt: got %0d want %0d", bus2.stall_cnt, exp_stall2); end
        bus2.instr_valid = 1'b0; bus2.instr = '0;
    endtask

    task automatic test_reset_mid_stall();
        bus1.instr = mk(5'd1, 9'd5, 9'd1, 9'd2); bus1.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus1.instr = mk(5'd1, 9'd6, 9'd5, 9'd0);
        #1;
        tests_run++; if (bus1.instr_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_stall_ready: got %b want 0", bus1.instr_ready); end
        #1 rst_n = 1'b0;
        #1;
        tests_run++; if (bus1.OpCode !== 5'd0 || bus1.Rd !== 9'd0 || bus1.Rs !== 9'd0 || bus1.issue_valid !== 1'b0)
            begin tests_failed++; $display("FAIL rst_async_outputs: got op=%0d rd=%0d rs=%0d v=%b want all 0", bus1.OpCode, bus1.Rd, bus1.Rs, bus1.issue_valid); end
        tests_run++; if (bus1.stall_cnt !== 16'd0) begin tests_failed++; $display("FAIL rst_async_stall_cnt: got %0d want 0", bus1.stall_cnt); end
        tests_run++; if (bus1.instr_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_sb_cleared: got ready=%b want 1", bus1.instr_ready); end
        exp_stall1 = 0;
        @(posedge clk); #1;
        tests_run++; if (bus1.issue_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_held: got v=%b want 0", bus1.issue_valid); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (bus1.issue_valid !== 1'b1 || bus1.Rs !== 9'd5 || bus1.Rd !== 9'd6) begin tests_failed++; $display("FAIL rst_reissue: got v=%b rs=%0d rd=%0d want 1 5 6", bus1.issue_valid, bus1.Rs, bus1.Rd); end
        tests_run++; if (bus1.stall_cnt !== 16'(exp_stall1)) begin tests_failed++; $display("FAIL rst_reissue_stall_cnt: got %0d want %0d", bus1.stall_cnt, exp_stall1); end
        idle1();
    endtask

    initial begin
        test_reset();
        test_issue();
        test_raw();
        test_load_use();
        test_flush();
        test_full();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/id_issue_unit.md
Name: id_issue_unit

Overview:
- Producer side of the ID/EX pipeline interface: decodes the 32-bit instruction held in IF/ID and drives the OpCode/Rd/Rs/Rt/Dir fields into the ID/EX register.
- A small scoreboard of in-flight register writes detects hazards and inserts NOP bubbles while back-pressuring fetch.
- Sits between the IF/ID register and the ID/EX register; EX supplies a flush for taken branches.

Parameters:
- SB_ENTRIES, 4: number of in-flight write slots in the scoreboard (1-8).
- WB_LAT, 3: cycles a write stays pending after issue (2-15).
- WR_MASK, 32'h0000_FFFE: bit[op]=1 means opcode op writes Rd.
- RS_MASK, 32'h0000_FFFE: bit[op]=1 means opcode op reads Rs.
- RT_MASK, 32'h0000_0FFE: bit[op]=1 means opcode op reads Rt.
- LOAD_MASK, 32'h0000_1000: bit[op]=1 marks a load (opcode 12 by default).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  IF/ID instruction: [31:27] op, [26:18] rd, [17:9] rs, [8:0] rt, [26:0] dir.
- instr_valid  in  1  instr holds a real instruction.
- instr_ready  out  1  combinational; instr is consumed this cycle.
- flush  in  1  squash the instruction in ID this cycle.
- OpCode  out  5  registered op to ID/EX.
- Rd / Rs / Rt  out  9 each  registered register indices.
- Dir  out  27  registered instr[26:0].
- issue_valid  out  1  registered; 1 = real instruction, 0 = bubble.
- stall_cnt  out  16  saturating count of hazard-stall cycles.

Behaviour:
- Reset (async, rst_n=0): OpCode, Rd, Rs, Rt, Dir, issue_valid and stall_cnt are all 0. All scoreboard entries are invalid. Reset mid-stall discards all pending entries.
- Decode: op=instr[31:27]. wr=WR_MASK[op] && rd!=0. rs_rd=RS_MASK[op] && rs!=0. rt_rd=RT_MASK[op] && rt!=0. Index 0 is hardwired zero: never a hazard, never allocated.
- Scoreboard entry = {valid, rd[8:0], is_load, cnt[3:0]}.
- hazard = any valid entry whose rd equals rs (with rs_rd), equals rt (with rt_rd), or equals rd (with wr; WAW).
- full = wr && no invalid entry exists at the current cycle start.
- instr_ready = !hazard && !full && !flush. It is 1 when instr_valid=0.
- Issue (instr_valid && instr_ready): at the next edge, the outputs take the decoded fields and issue_valid=1. Latency is 1 cycle.
- Bubble (any other case): at the next edge, OpCode=0, Rd=Rs=Rt=0, Dir=0, issue_valid=0.
- Allocation: on an issue with wr, the lowest-index invalid entry is loaded with valid=1, rd, is_load=LOAD_MASK[op], cnt=WB_LAT.
- Aging: each edge, every valid entry not being allocated decrements cnt. An entry with cnt==1 becomes invalid at that edge. A pending write therefore blocks dependents for exactly WB_LAT cycles after the issue edge.
- Simultaneous free and allocate: a slot freeing at an edge is not allocatable at that same edge, because full is evaluated on the pre-edge state.
- Flush: forces a bubble and drops the ID instruction. The scoreboard is untouched, which is conservative and harmless. Flush has priority over issue.
- stall_cnt: +1 each cycle with instr_valid && !flush && (hazard || full). It saturates at 16'hFFFF.

Optional Feature:
- Macro: ID_ISSUE_FORWARD_EN.
- Defined: EX/MEM forwarding is assumed. RAW hazards count only against entries with is_load=1 && cnt==WB_LAT, i.e. a load-use gives a single bubble. WAW and full still stall as above.
- Undefined: all RAW matches stall for the full WB_LAT window.

Test Plan:
- Reset, then an independent ADD (op=1, rd=5, rs=1, rt=2) with valid=1 -> instr_ready=1; next cycle OpCode=1, Rd=5, Rs=1, Rt=2, issue_valid=1.
- op=1 rd=5, followed by op=1 rs=5 (FORWARD off, WB_LAT=3) -> the second instruction is held with instr_ready=0 for 3 cycles, 3 bubbles (OpCode=0), stall_cnt=3, then issues.
- FORWARD_EN on: load op=12 rd=7, followed by op=1 rs=7 -> exactly 1 bubble. The same sequence with op=1 as the producer -> 0 bubbles.
- SB_ENTRIES=4: five back-to-back writers to rd=10..14 -> the fifth stalls on full until the first entry frees, then issues. Writer to rd=0 -> no allocation, no stall.
- flush=1 with a valid instruction -> instr_ready=0; next cycle issue_valid=0, OpCode=0. The instruction reissues only after flush drops.
- rst_n pulsed low while a hazard stall is active -> all outputs 0 asynchronously. After release, the previously stalled instruction issues immediately.
